// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the register file: two buffered requesters share one write port
// under round-robin arbitration, plus a drain-then-zero clear sequencer.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_dest,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_dest,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_write_dest,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  grant_a,
    output logic                  grant_b
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ClrW = ADDR_WIDTH + 1;
    localparam int unsigned EntW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StArb, StDrain, StClear} state_e;

    state_e r_state;
    state_e w_state_next;

    // Index 0 is requester A, index 1 is requester B.
    logic [EntW-1:0] r_mem  [2][FIFO_DEPTH];
    logic [PtrW-1:0] r_wptr [2];
    logic [PtrW-1:0] r_rptr [2];
    logic [CntW-1:0] r_cnt  [2];
    logic            r_last_b;
    logic [ClrW-1:0] r_clr_cnt;
    logic [ClrW-1:0] w_clr_cnt_next;

    logic [1:0]      w_valid;
    logic [1:0]      w_ready;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic [1:0]      w_nonempty;
    logic [EntW-1:0] w_entry [2];
    logic [EntW-1:0] w_head  [2];
    logic            w_arb_en;
    logic            w_pick_a;
    logic            w_pick_b;

    logic                  r_wen;
    logic                  r_ga;
    logic                  r_gb;
    logic [ADDR_WIDTH-1:0] r_dest;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_wen_next;
    logic                  w_ga_next;
    logic                  w_gb_next;
    logic [ADDR_WIDTH-1:0] w_dest_next;
    logic [DATA_WIDTH-1:0] w_data_next;

    // Handshake and arbitration; pops only see entries already stored, so no fall-through.
    always_comb begin
        w_valid    = {b_valid, a_valid};
        w_entry[0] = {a_dest, a_data};
        w_entry[1] = {b_dest, b_data};
        w_arb_en   = (r_state == StArb) || (r_state == StDrain);
        for (int i = 0; i < 2; i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            w_ready[i]    = (r_state == StArb) && (r_cnt[i] != CntFull) && !rst;
            w_push[i]     = w_valid[i] && w_ready[i];
            w_head[i]     = r_mem[i][r_rptr[i]];
        end
        w_pick_a = w_arb_en && w_nonempty[0] && (!w_nonempty[1] || r_last_b);
        w_pick_b = w_arb_en && w_nonempty[1] && !w_pick_a;
        w_pop    = {w_pick_b, w_pick_a};
    end

    assign a_ready = w_ready[0];
    assign b_ready = w_ready[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
                for (int j = 0; j < int'(FIFO_DEPTH); j++) begin
                    r_mem[i][j] <= '0;
                end
            end
            r_last_b <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_mem[i][r_wptr[i]] <= w_entry[i];
                    r_wptr[i]           <= r_wptr[i] + PtrW'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PtrW'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CntW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CntW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (w_pop[0]) begin
                r_last_b <= 1'b0;
            end else if (w_pop[1]) begin
                r_last_b <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StArb;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StArb: begin
                if (clear_req) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (!w_nonempty[0] && !w_nonempty[1]) begin
                    w_state_next = StClear;
                end
            end
            StClear: begin
                // Counter MSB set means all addresses have been zeroed.
                if (r_clr_cnt[ADDR_WIDTH]) begin
                    w_state_next = StArb;
                end
            end
            default: w_state_next = StArb;
        endcase
    end

    always_comb begin
        w_wen_next     = 1'b0;
        w_ga_next      = 1'b0;
        w_gb_next      = 1'b0;
        w_dest_next    = r_dest;
        w_data_next    = r_data;
        w_clr_cnt_next = r_clr_cnt;
        if (w_pop[0]) begin
            w_wen_next                 = 1'b1;
            w_ga_next                  = 1'b1;
            {w_dest_next, w_data_next} = w_head[0];
        end else if (w_pop[1]) begin
            w_wen_next                 = 1'b1;
            w_gb_next                  = 1'b1;
            {w_dest_next, w_data_next} = w_head[1];
        end else if (r_state == StClear) begin
            if (!r_clr_cnt[ADDR_WIDTH]) begin
                w_wen_next     = 1'b1;
                w_dest_next    = r_clr_cnt[ADDR_WIDTH-1:0];
                w_data_next    = '0;
                w_clr_cnt_next = r_clr_cnt + ClrW'(1);
            end else begin
                w_clr_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen     <= 1'b0;
            r_ga      <= 1'b0;
            r_gb      <= 1'b0;
            r_dest    <= '0;
            r_data    <= '0;
            r_clr_cnt <= '0;
        end else begin
            r_wen     <= w_wen_next;
            r_ga      <= w_ga_next;
            r_gb      <= w_gb_next;
            r_dest    <= w_dest_next;
            r_data    <= w_data_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    assign busy          = (r_state != StArb);
    assign rf_write_en   = r_wen;
    assign grant_a       = r_ga;
    assign grant_b       = r_gb;
    assign rf_write_dest = r_dest;
    assign rf_write_data = r_data;

endmodule
